wb_stage_arb: RTL and testbench

Parametrised writeback stage for the pipelined MIPS core. It registers the MEM-stage result, performs load extension and link-address generation, and drives the single register-file write port. It also accepts write-backs from the multi-cycle multiply/divide unit (MDU) into a small FIFO. That FIFO shares the write port with the pipeline: pipeline writes win, and queued MDU writes fill the idle port cycles.

---
 rtl/wb_stage_arb.sv | 188 ++++++++++++++++++
 tb/tb_wb_stage_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_arb.sv
// Writeback stage: registers the MEM result, extends loads, builds link values, and shares
// the register-file write port with a small in-order FIFO of multiply/divide results.
module wb_stage_arb #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int PC_OFFSET  = 8
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DW-1:0]                    in_pc,
  input  logic [DW-1:0]                    in_res,
  input  logic [DW-1:0]                    in_mem_rdata,
  input  logic [AW-1:0]                    in_waddr,
  input  logic                             in_reg_write,
  input  logic                             in_mem_to_reg,
  input  logic                             in_link,
  input  logic [1:0]                       in_ld_size,
  input  logic                             in_ld_signed,
  input  logic                             mdu_valid,
  output logic                             mdu_ready,
  input  logic [AW-1:0]                    mdu_waddr,
  input  logic [DW-1:0]                    mdu_wdata,
  output logic                             RegWrite,
  output logic [AW-1:0]                    RegWAddr,
  output logic [DW-1:0]                    RegWData,
  output logic [DW-1:0]                    PC,
  output logic [(2**AW)-1:0]               pend_mask,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  q_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic          r_valid;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_res;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_waddr;
  logic          r_reg_write;
  logic          r_mem_to_reg;
  logic          r_link;
  logic [1:0]    r_ld_size;
  logic          r_ld_signed;

  logic [AW-1:0]         r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0]         r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_occ;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic          w_not_full;
  logic          w_accept;
  logic          w_push;
  logic          w_pipe_wr;
  logic          w_pop;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_pipe_data;
  logic [(2**AW)-1:0] w_pend;

  // A full queue forces a pipeline bubble so the head is guaranteed a free port cycle.
  assign w_not_full = (r_count != CW'(FIFO_DEPTH));
  assign in_ready   = w_not_full;
  assign mdu_ready  = w_not_full;
  assign w_accept   = in_valid && w_not_full;
  assign w_push     = mdu_valid && w_not_full && (mdu_waddr != '0);
  assign w_pipe_wr  = r_valid && r_reg_write && (r_waddr != '0);
  assign w_pop      = !w_pipe_wr && (r_count != '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_res        <= '0;
      r_rdata      <= '0;
      r_waddr      <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_link       <= 1'b0;
      r_ld_size    <= '0;
      r_ld_signed  <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_pc         <= in_pc;
      r_res        <= in_res;
      r_rdata      <= in_mem_rdata;
      r_waddr      <= in_waddr;
      r_reg_write  <= in_reg_write;
      r_mem_to_reg <= in_mem_to_reg;
      r_link       <= in_link;
      r_ld_size    <= in_ld_size;
      r_ld_signed  <= in_ld_signed;
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Little-endian lane select; half-word misalignment is trapped upstream so res[0] is ignored.
  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_res[1:0])
      2'd0: w_byte = r_rdata[7:0];
      2'd1: w_byte = r_rdata[15:8];
      2'd2: w_byte = r_rdata[23:16];
      2'd3: w_byte = r_rdata[31:24];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_res[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_ld_size)
      2'd0:    w_load = r_ld_signed ? {{(DW-8){w_byte[7]}}, w_byte} : {{(DW-8){1'b0}}, w_byte};
      2'd1:    w_load = r_ld_signed ? {{(DW-16){w_half[15]}}, w_half} : {{(DW-16){1'b0}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    if (r_link)
      w_pipe_data = r_pc + DW'(PC_OFFSET);
    else if (r_mem_to_reg)
      w_pipe_data = w_load;
    else
      w_pipe_data = r_res;
  end

  always_comb begin
    RegWrite = 1'b0;
    RegWAddr = '0;
    RegWData = '0;
    if (w_pipe_wr) begin
      RegWrite = 1'b1;
      RegWAddr = r_waddr;
      RegWData = w_pipe_data;
    end else if (w_pop) begin
      RegWrite = 1'b1;
      RegWAddr = r_fifo_addr[r_rd_ptr];
      RegWData = r_fifo_data[r_rd_ptr];
    end
  end

  // Push and pop never target the same slot: pushing needs not-full, popping needs not-empty.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_occ[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_occ[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= mdu_waddr;
      r_fifo_data[r_wr_ptr] <= mdu_wdata;
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_occ[i])
        w_pend[r_fifo_addr[i]] = 1'b1;
    end
  end

  assign pend_mask = w_pend;
  assign q_count   = r_count;
  assign PC        = r_pc;

endmodule

// File: tb/tb_wb_stage_arb.sv
// Directed bench for wb_stage_arb: load extension, link, MDU queueing, arbitration and reset.
module tb_wb_stage_arb;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_res;
  logic [31:0] in_mem_rdata;
  logic [4:0]  in_waddr;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic        in_link;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        RegWrite;
  logic [4:0]  RegWAddr;
  logic [31:0] RegWData;
  logic [31:0] PC;
  logic [31:0] pend_mask;
  logic [2:0]  q_count;

  int vecCount  = 0;
  int missCount = 0;

  wb_stage_arb #(.DW(32), .AW(5), .FIFO_DEPTH(4), .PC_OFFSET(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_res(in_res),
    .in_mem_rdata(in_mem_rdata), .in_waddr(in_waddr), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_link(in_link), .in_ld_size(in_ld_size),
    .in_ld_signed(in_ld_signed),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .RegWrite(RegWrite), .RegWAddr(RegWAddr), .RegWData(RegWData), .PC(PC),
    .pend_mask(pend_mask), .q_count(q_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic stageIn(input logic v, input logic [31:0] pc, input logic [31:0] res,
                         input logic [31:0] rdata, input logic [4:0] wa, input logic rw,
                         input logic m2r, input logic lnk, input logic [1:0] sz, input logic sgn);
    in_valid = v; in_pc = pc; in_res = res; in_mem_rdata = rdata; in_waddr = wa;
    in_reg_write = rw; in_mem_to_reg = m2r; in_link = lnk; in_ld_size = sz; in_ld_signed = sgn;
  endtask

  task automatic mduIn(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    mdu_valid = v; mdu_waddr = wa; mdu_wdata = wd;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    stageIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mduIn(0, 0, 0);
    tick(); tick();
    Rst = 1'b0;
    vecCount++; if (RegWrite !== 1'b0) begin missCount++; $display("[TB] FAIL rst_wr got %b want 0", RegWrite); end
    vecCount++; if (RegWAddr !== 5'd0) begin missCount++; $display("[TB] FAIL rst_waddr got %0d want 0", RegWAddr); end
    vecCount++; if (RegWData !== 32'h0) begin missCount++; $display("[TB] FAIL rst_wdata got %h want 0", RegWData); end
    vecCount++; if (PC !== 32'h0) begin missCount++; $display("[TB] FAIL rst_pc got %h want 0", PC); end
    vecCount++; if (pend_mask !== 32'h0) begin missCount++; $display("[TB] FAIL rst_pend got %h want 0", pend_mask); end
    vecCount++; if (q_count !== 3'd0) begin missCount++; $display("[TB] FAIL rst_qcount got %0d want 0", q_count); end
    vecCount++; if (mdu_ready !== 1'b1) begin missCount++; $display("[TB] FAIL rst_mdu_ready got %b want 1", mdu_ready); end
    vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] exp [7];
    exp[0] = 32'h00000080; exp[1] = 32'hFFFFFF80; exp[2] = 32'hFFFF8001; exp[3] = 32'h00000034;
    exp[4] = 32'h0000ABCD; exp[5] = 32'h8001ABCD; exp[6] = 32'h00001003;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: stageIn(1, 32'h100, 32'h1003, 32'h80FF1234, 5'd2, 1, 1, 0, 2'd0, 0);
        1: stageIn(1, 32'h104, 32'h1003, 32'h80FF1234, 5'd2, 1, 1, 0, 2'd0, 1);
        2: stageIn(1, 32'h108, 32'h2002, 32'h8001ABCD, 5'd2, 1, 1, 0, 2'd1, 1);
        3: stageIn(1, 32'h10C, 32'h1000, 32'h80FF1234, 5'd2, 1, 1, 0, 2'd0, 1);
        4: stageIn(1, 32'h110, 32'h2001, 32'h8001ABCD, 5'd2, 1, 1, 0, 2'd1, 0);
        5: stageIn(1, 32'h114, 32'h2000, 32'h8001ABCD, 5'd2, 1, 1, 0, 2'd2, 1);
        default: stageIn(1, 32'h118, 32'h1003, 32'h8001ABCD, 5'd2, 1, 0, 0, 2'd0, 0);
      endcase
      tick();
      vecCount++;
      if (RegWrite !== 1'b1 || RegWAddr !== 5'd2 || RegWData !== exp[i])
        begin missCount++; $display("[TB] FAIL load%0d got wr=%b a=%0d d=%h want wr=1 a=2 d=%h", i, RegWrite, RegWAddr, RegWData, exp[i]); end
    end
    vecCount++; if (PC !== 32'h118) begin missCount++; $display("[TB] FAIL load_pc got %h want 118", PC); end
  endtask

  task automatic test_link();
    stageIn(1, 32'h3000, 32'h55, 32'h0, 5'd31, 1, 1, 1, 2'd2, 0);
    tick();
    vecCount++;
    if (RegWrite !== 1'b1 || RegWAddr !== 5'd31 || RegWData !== 32'h3008)
      begin missCount++; $display("[TB] FAIL jal got wr=%b a=%0d d=%h want wr=1 a=31 d=3008", RegWrite, RegWAddr, RegWData); end
    stageIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vecCount++; if (RegWrite !== 1'b0) begin missCount++; $display("[TB] FAIL bubble_wr got %b want 0", RegWrite); end
  endtask

  task automatic test_mdu_wait();
    stageIn(1, 32'h400, 32'h333, 32'h0, 5'd3, 1, 0, 0, 2'd2, 0);
    mduIn(1, 5'd5, 32'h11);
    tick();
    mduIn(0, 0, 0);
    vecCount++; if (RegWAddr !== 5'd3 || RegWData !== 32'h333) begin missCount++; $display("[TB] FAIL wait_pipe got a=%0d d=%h want a=3 d=333", RegWAddr, RegWData); end
    vecCount++; if (q_count !== 3'd1) begin missCount++; $display("[TB] FAIL wait_qcount got %0d want 1", q_count); end
    vecCount++; if (pend_mask !== 32'h20) begin missCount++; $display("[TB] FAIL wait_pend got %h want 20", pend_mask); end
    tick();
    vecCount++; if (RegWAddr !== 5'd3 || q_count !== 3'd1) begin missCount++; $display("[TB] FAIL wait_hold got a=%0d q=%0d want a=3 q=1", RegWAddr, q_count); end
    stageIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vecCount++;
    if (RegWrite !== 1'b1 || RegWAddr !== 5'd5 || RegWData !== 32'h11)
      begin missCount++; $display("[TB] FAIL wait_drain got wr=%b a=%0d d=%h want wr=1 a=5 d=11", RegWrite, RegWAddr, RegWData); end
    tick();
    vecCount++;
    if (q_count !== 3'd0 || pend_mask !== 32'h0 || RegWrite !== 1'b0)
      begin missCount++; $display("[TB] FAIL wait_empty got q=%0d pend=%h wr=%b want q=0 pend=0 wr=0", q_count, pend_mask, RegWrite); end
  endtask

  task automatic test_full();
    stageIn(1, 32'h400, 32'h333, 32'h0, 5'd3, 1, 0, 0, 2'd2, 0);
    for (int k = 0; k < 4; k++) begin
      mduIn(1, 5'(6 + k), 32'h100 + 32'(k));
      tick();
      vecCount++;
      if (q_count !== 3'(k + 1) || RegWAddr !== 5'd3)
        begin missCount++; $display("[TB] FAIL fill%0d got q=%0d a=%0d want q=%0d a=3", k, q_count, RegWAddr, k + 1); end
    end
    mduIn(0, 0, 0);
    vecCount++;
    if (mdu_ready !== 1'b0 || in_ready !== 1'b0 || pend_mask !== 32'h3C0)
      begin missCount++; $display("[TB] FAIL full got mrdy=%b irdy=%b pend=%h want 0 0 3c0", mdu_ready, in_ready, pend_mask); end
    stageIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      vecCount++;
      if (RegWrite !== 1'b1 || RegWAddr !== 5'(6 + k) || RegWData !== 32'h100 + 32'(k) || q_count !== 3'(4 - k))
        begin missCount++; $display("[TB] FAIL drain%0d got wr=%b a=%0d d=%h q=%0d want a=%0d d=%h q=%0d", k, RegWrite, RegWAddr, RegWData, q_count, 6 + k, 32'h100 + 32'(k), 4 - k); end
    end
    tick();
    vecCount++;
    if (q_count !== 3'd0 || in_ready !== 1'b1 || RegWrite !== 1'b0)
      begin missCount++; $display("[TB] FAIL drained got q=%0d irdy=%b wr=%b want 0 1 0", q_count, in_ready, RegWrite); end
  endtask

  task automatic test_r0();
    mduIn(1, 5'd0, 32'hDEAD);
    tick();
    mduIn(0, 0, 0);
    vecCount++;
    if (q_count !== 3'd0 || mdu_ready !== 1'b1 || RegWrite !== 1'b0 || pend_mask !== 32'h0)
      begin missCount++; $display("[TB] FAIL r0_push got q=%0d mrdy=%b wr=%b pend=%h want 0 1 0 0", q_count, mdu_ready, RegWrite, pend_mask); end
    stageIn(1, 32'h500, 32'h777, 32'h0, 5'd0, 1, 0, 0, 2'd2, 0);
    mduIn(1, 5'd4, 32'h44);
    tick();
    stageIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mduIn(0, 0, 0);
    vecCount++;
    if (RegWrite !== 1'b1 || RegWAddr !== 5'd4 || RegWData !== 32'h44)
      begin missCount++; $display("[TB] FAIL r0_pipe got wr=%b a=%0d d=%h want wr=1 a=4 d=44", RegWrite, RegWAddr, RegWData); end
    tick();
    vecCount++; if (q_count !== 3'd0) begin missCount++; $display("[TB] FAIL r0_pop got q=%0d want 0", q_count); end
  endtask

  task automatic test_same_reg_order();
    stageIn(1, 32'h600, 32'h999, 32'h0, 5'd7, 1, 0, 0, 2'd2, 0);
    mduIn(1, 5'd10, 32'hA);
    tick();
    mduIn(1, 5'd10, 32'hB);
    tick();
    mduIn(0, 0, 0);
    stageIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecCount++; if (pend_mask !== 32'h400) begin missCount++; $display("[TB] FAIL order_pend got %h want 400", pend_mask); end
    tick();
    vecCount++; if (RegWAddr !== 5'd10 || RegWData !== 32'hA) begin missCount++; $display("[TB] FAIL order_first got a=%0d d=%h want a=10 d=a", RegWAddr, RegWData); end
    tick();
    vecCount++; if (RegWAddr !== 5'd10 || RegWData !== 32'hB) begin missCount++; $display("[TB] FAIL order_second got a=%0d d=%h want a=10 d=b", RegWAddr, RegWData); end
    tick();
    vecCount++; if (q_count !== 3'd0 || pend_mask !== 32'h0) begin missCount++; $display("[TB] FAIL order_empty got q=%0d pend=%h want 0 0", q_count, pend_mask); end
  endtask

  task automatic test_reset_mid();
    stageIn(1, 32'h700, 32'h123, 32'h0, 5'd3, 1, 0, 0, 2'd2, 0);
    for (int k = 0; k < 3; k++) begin
      mduIn(1, 5'(12 + k), 32'h200 + 32'(k));
      tick();
    end
    mduIn(0, 0, 0);
    vecCount++; if (q_count !== 3'd3) begin missCount++; $display("[TB] FAIL pre_rst_q got %0d want 3", q_count); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    stageIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecCount++;
    if (q_count !== 3'd0 || RegWrite !== 1'b0 || pend_mask !== 32'h0 || mdu_ready !== 1'b1 || PC !== 32'h0)
      begin missCount++; $display("[TB] FAIL mid_rst got q=%0d wr=%b pend=%h mrdy=%b pc=%h want 0 0 0 1 0", q_count, RegWrite, pend_mask, mdu_ready, PC); end
    tick();
    vecCount++;
    if (RegWrite !== 1'b0 || q_count !== 3'd0)
      begin missCount++; $display("[TB] FAIL post_rst got wr=%b q=%0d want 0 0", RegWrite, q_count); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_link();
    test_mdu_wait();
    test_full();
    test_r0();
    test_same_reg_order();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
